// File: rtl/rope_pkg.sv
// Shared types and default sizing for the rope collision controller.
package rope_pkg;

  localparam int unsigned ROPES_NUM            = 6;
  localparam int unsigned TOGGLE_HOLDOFF_DEF   = 8;
  localparam int unsigned GRAB_LOSS_FRAMES_DEF = 2;

  typedef logic [$clog2(ROPES_NUM)-1:0] rope_idx_t;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    HELD         = 2'd1,
    RELEASE_WAIT = 2'd2
  } grab_state_t;

endpackage

// File: rtl/rope_toggle_unit.sv
// Per-rope border-hit accumulator, toggle holdoff counter and toggle pulse register.
module rope_toggle_unit
  import rope_pkg::*;
#(
  parameter int unsigned HOLDOFF = TOGGLE_HOLDOFF_DEF
) (
  input  logic clk,
  input  logic resetN,
  input  logic sof,
  input  logic armed,
  input  logic rope_dr,
  input  logic border_dr,
  output logic dir_toggle
);

  localparam int unsigned HW = $clog2(HOLDOFF + 1);

  logic          hit_c;
  logic          border_hit_q, border_hit_d;
  logic [HW-1:0] holdoff_q, holdoff_d;
  logic          dir_toggle_q, dir_toggle_d;

  // Accumulate border overlap; at a frame boundary judge the finished frame and restart with pixel 0.
  always_comb begin
    hit_c        = rope_dr & border_dr;
    border_hit_d = border_hit_q | hit_c;
    holdoff_d    = holdoff_q;
    dir_toggle_d = 1'b0;
    if (sof) begin
      border_hit_d = hit_c;
      if (armed) begin
        if (border_hit_q && (holdoff_q == '0)) begin
          dir_toggle_d = 1'b1;
          holdoff_d    = HW'(HOLDOFF);
        end else if (holdoff_q != '0) begin
          holdoff_d = holdoff_q - HW'(1);
        end
      end
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (resetN) begin
      border_hit_q <= 1'b0;
      holdoff_q    <= '0;
      dir_toggle_q <= 1'b0;
    end else begin
      border_hit_q <= border_hit_d;
      holdoff_q    <= holdoff_d;
      dir_toggle_q <= dir_toggle_d;
    end
  end

  assign dir_toggle = dir_toggle_q;

endmodule

// File: rtl/rope_collision_ctrl.sv
// Rope collision controller: frame-level border toggles and player grab tracking.
// Optional macro ROPE_GRAB_STICKY_EN: a held rope is never released on misses,
// only handed over to another rope the player overlaps.
module rope_collision_ctrl
  import rope_pkg::*;
#(
  parameter int unsigned ROPES            = ROPES_NUM,
  parameter int unsigned TOGGLE_HOLDOFF   = TOGGLE_HOLDOFF_DEF,
  parameter int unsigned GRAB_LOSS_FRAMES = GRAB_LOSS_FRAMES_DEF
) (
  input  logic                     clk,
  input  logic                     resetN,
  input  logic                     startOfFrame,
  input  logic [ROPES-1:0]         ropeDR,
  input  logic                     playerDR,
  input  logic                     borderDR,
  output logic [ROPES-1:0]         dirToggle,
  output logic                     grabValid,
  output logic [$clog2(ROPES)-1:0] grabbedRope,
  output logic                     anyRopeHit
);

  localparam int unsigned IDX_W = $clog2(ROPES);

  grab_state_t      state_q, state_d;
  logic [ROPES-1:0] player_hit_q, player_hit_d;
  logic [IDX_W-1:0] grabbed_q, grabbed_d;
  logic             grab_valid_q, grab_valid_d;
  logic             any_hit_q, any_hit_d;
  logic             armed_q, armed_d;
  logic [IDX_W-1:0] low_idx_c;
  logic             low_found_c;
`ifndef ROPE_GRAB_STICKY_EN
  localparam int unsigned MISS_W = $clog2(GRAB_LOSS_FRAMES + 1);
  logic [MISS_W-1:0] miss_q, miss_d;
`endif

  // One border toggle unit per rope; the first boundary after reset only arms them.
  for (genvar g = 0; g < int'(ROPES); g++) begin : g_toggle
    rope_toggle_unit #(
      .HOLDOFF(TOGGLE_HOLDOFF)
    ) u_toggle (
      .clk       (clk),
      .resetN    (resetN),
      .sof       (startOfFrame),
      .armed     (armed_q),
      .rope_dr   (ropeDR[g]),
      .border_dr (borderDR),
      .dir_toggle(dirToggle[g])
    );
  end

  // Lowest-index priority encoder over the previous frame's player hits.
  always_comb begin
    low_idx_c   = '0;
    low_found_c = 1'b0;
    for (int i = 0; i < int'(ROPES); i++) begin
      if (player_hit_q[i] && !low_found_c) begin
        low_idx_c   = IDX_W'(i);
        low_found_c = 1'b1;
      end
    end
  end

  // Player-hit accumulation, frame summary and grab FSM next state.
  always_comb begin
    state_d      = state_q;
    grabbed_d    = grabbed_q;
    grab_valid_d = grab_valid_q;
    any_hit_d    = any_hit_q;
    armed_d      = armed_q | startOfFrame;
    player_hit_d = player_hit_q | (ropeDR & {ROPES{playerDR}});
`ifndef ROPE_GRAB_STICKY_EN
    miss_d       = miss_q;
`endif
    if (startOfFrame) begin
      player_hit_d = ropeDR & {ROPES{playerDR}};
      any_hit_d    = armed_q & (|player_hit_q);
      if (armed_q) begin
        case (state_q)
          IDLE: begin
            if (low_found_c) begin
              state_d      = HELD;
              grabbed_d    = low_idx_c;
              grab_valid_d = 1'b1;
`ifndef ROPE_GRAB_STICKY_EN
              miss_d       = '0;
`endif
            end
          end
          HELD: begin
`ifdef ROPE_GRAB_STICKY_EN
            if (!player_hit_q[grabbed_q] && low_found_c) begin
              grabbed_d = low_idx_c;
            end
`else
            if (player_hit_q[grabbed_q]) begin
              miss_d = '0;
            end else if (miss_q == MISS_W'(GRAB_LOSS_FRAMES - 1)) begin
              state_d      = RELEASE_WAIT;
              grab_valid_d = 1'b0;
              miss_d       = '0;
            end else begin
              miss_d = miss_q + MISS_W'(1);
            end
`endif
          end
          RELEASE_WAIT: begin
            if (player_hit_q == '0) begin
              state_d = IDLE;
            end
          end
          default: begin
            state_d      = IDLE;
            grab_valid_d = 1'b0;
          end
        endcase
      end
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (resetN) begin
      state_q      <= IDLE;
      player_hit_q <= '0;
      grabbed_q    <= '0;
      grab_valid_q <= 1'b0;
      any_hit_q    <= 1'b0;
      armed_q      <= 1'b0;
`ifndef ROPE_GRAB_STICKY_EN
      miss_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      player_hit_q <= player_hit_d;
      grabbed_q    <= grabbed_d;
      grab_valid_q <= grab_valid_d;
      any_hit_q    <= any_hit_d;
      armed_q      <= armed_d;
`ifndef ROPE_GRAB_STICKY_EN
      miss_q       <= miss_d;
`endif
    end
  end

  assign grabValid   = grab_valid_q;
  assign grabbedRope = grabbed_q;
  assign anyRopeHit  = any_hit_q;

endmodule

// File: doc/rope_collision_ctrl.md
Name: rope_collision_ctrl

Overview:
- Sits directly upstream of the rope display array; produces its per-rope `dirToggle` vector.
- Consumes the per-rope drawing requests, the player drawing request and the screen-border drawing request.
- Accumulates pixel-level overlaps across one frame and issues one-cycle direction-toggle pulses at frame boundaries.
- Tracks which rope, if any, the player is currently holding, for the player movement logic.

Parameters:
- ROPES, 6, number of ropes; must equal the rope count of the display array.
- TOGGLE_HOLDOFF, 8, frames a rope ignores border hits after it has toggled.
- GRAB_LOSS_FRAMES, 2, consecutive frames without player/rope overlap before a held rope is released.

Ports:
- clk  in  1  system clock.
- resetN  in  1  synchronous reset. Active-high (1 = reset) despite the name; sampled on the rising edge of clk.
- startOfFrame  in  1  one-cycle pulse at the first pixel of each frame.
- ropeDR  in  ROPES  per-rope drawing request for the current pixel.
- playerDR  in  1  player drawing request for the current pixel.
- borderDR  in  1  screen-border drawing request for the current pixel.
- dirToggle  out  ROPES  one-cycle toggle pulses, one bit per rope.
- grabValid  out  1  player is holding a rope.
- grabbedRope  out  $clog2(ROPES)  index of the held rope; valid only while grabValid=1.
- anyRopeHit  out  1  registered: any rope overlapped the player during the previous frame.

Behaviour:
- Reset (resetN=1): all accumulators, holdoff counters and miss counter go to 0; FSM goes to IDLE. Outputs: dirToggle=0, grabValid=0, grabbedRope=0, anyRopeHit=0.
- Per-rope accumulators:
  - borderHit[i] |= ropeDR[i] & borderDR each cycle.
  - playerHit[i] |= ropeDR[i] & playerDR each cycle.
- Frame boundary, on the cycle startOfFrame=1:
  - Evaluate the latched accumulators (previous frame).
  - Re-initialise each accumulator with the current-cycle overlap only, so pixel 0 of the new frame is counted in the new frame and never lost.
- Toggle, per rope, evaluated at startOfFrame:
  - If borderHit[i]=1 and holdoff[i]=0: dirToggle[i]=1 on the next cycle for exactly one cycle; holdoff[i] loads TOGGLE_HOLDOFF.
  - Else if holdoff[i]>0: holdoff[i] decrements by 1.
  - Latency: pulse appears 1 cycle after the startOfFrame edge.
  - Multiple ropes may toggle in the same cycle.
  - Holdoff counters are $clog2(TOGGLE_HOLDOFF+1) bits wide, saturate at 0 and never wrap.
- Grab FSM, transitions only at startOfFrame:
  - IDLE: if any playerHit bit is set, take the lowest set index. Go to HELD, grabbedRope=index, grabValid=1, missCnt=0.
  - HELD, playerHit[grabbedRope]=1: stay, missCnt=0. Hits on other ropes are ignored.
  - HELD, playerHit[grabbedRope]=0: missCnt increments. When missCnt reaches GRAB_LOSS_FRAMES, go to RELEASE_WAIT, grabValid=0.
  - RELEASE_WAIT: on the first frame with all playerHit bits 0, go to IDLE. This prevents an immediate re-grab of an overlapping rope.
- anyRopeHit = OR of playerHit, registered at startOfFrame and held for the whole frame.
- Outputs are registered and combinational paths from inputs to outputs are forbidden.
- startOfFrame asserted on consecutive cycles: each assertion is a frame boundary, so empty frames count as misses.
- Reset mid-frame: discards all partial accumulation; the first frame after reset never toggles.

Optional Feature:
- Macro ROPE_GRAB_STICKY_EN.
  - Defined: in HELD the FSM never releases on misses. It leaves only when a different rope overlaps the player for one full frame, switching grabbedRope to that rope's lowest index without passing through RELEASE_WAIT. missCnt logic is compiled out.
  - Undefined: miss-count release as described in Behaviour.

Decomposition:
- Package rope_pkg:
  - ROPES_NUM constant.
  - rope_idx_t typedef, logic [$clog2(ROPES_NUM)-1:0].
  - grab_state_t enum {IDLE, HELD, RELEASE_WAIT}.
  - Default TOGGLE_HOLDOFF and GRAB_LOSS_FRAMES constants.
- Sub-module rope_toggle_unit, generated ROPES times:
  - Contains the borderHit accumulator, holdoff counter and dirToggle register.
  - The parent holds the playerHit accumulators, the grab FSM and the lowest-index priority encoder.

Test Plan:
- Reset: resetN=1 for 3 cycles with random inputs -> all outputs 0; no dirToggle on the first startOfFrame after release.
- Border toggle: ropeDR[2]=borderDR=1 for 1 pixel in frame N -> dirToggle=6'b000100 for exactly 1 cycle after frame N+1's startOfFrame. The same hit repeated in frames N+1..N+8 -> no pulse; frame N+9 hit -> pulse.
- Pixel-0 boundary: overlap only on the startOfFrame cycle -> counted in the new frame; the pulse comes one frame later, not immediately.
- Grab priority: playerDR overlaps ropes 1 and 4 in the same frame -> grabValid=1, grabbedRope=1.
- Release (default build): player leaves rope 1 for 2 frames -> grabValid=0 in RELEASE_WAIT; still overlapping rope 4 -> no re-grab until one clear frame; overlap after that -> grabbedRope=4.
- ROPE_GRAB_STICKY_EN build: player leaves all ropes for 10 frames -> grabValid stays 1; rope 3 overlapped for a full frame -> grabbedRope=3 at the next startOfFrame.
